// File: rtl/reg_bus_arb.sv
// reg_bus_arb: two-requester round-robin arbiter in front of the MFUNC
// sub-register banks. One transaction in flight, fixed IDLE->XFER->RESP
// occupancy. addr[15:12] selects the bank, addr[11:0] is the register address.
module reg_bus_arb #(
  parameter int             NUM_SUB  = 4,
  parameter int             DW       = 32,
  parameter logic [DW-1:0]  ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [15:0]           m0_addr,
  input  logic [DW-1:0]         m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DW-1:0]         m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [15:0]           m1_addr,
  input  logic [DW-1:0]         m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DW-1:0]         m1_rdata,
  output logic                  m1_err,
  output logic [11:0]           sub_reg_addr,
  output logic [DW-1:0]         reg_wr_data,
  output logic [NUM_SUB-1:0]    sub_wr_en,
  input  logic [NUM_SUB*DW-1:0] sub_rd_data,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]         state_r;
  logic               last_gnt_r;   // 0 = m0 got the last grant, 1 = m1
  logic               win_r;        // owner of the transaction in flight
  logic               we_r;
  logic [3:0]         bank_r;
  logic               mapped_r;

  logic               pick_m1_s;
  logic               start_s;
  logic               sel_we_s;
  logic [15:0]        sel_addr_s;
  logic [DW-1:0]      sel_wdata_s;
  logic               sel_mapped_s;
  logic [NUM_SUB-1:0] sel_en_s;
  logic [DW-1:0]      rd_slice_s;
  logic [DW-1:0]      rsp_data_s;

  // Pick the winner among current requesters and decode its bank select.
  always_comb begin
    pick_m1_s = 1'b0;
    if (m0_req && m1_req) begin
      pick_m1_s = ~last_gnt_r;
    end else if (m1_req) begin
      pick_m1_s = 1'b1;
    end else begin
      pick_m1_s = 1'b0;
    end

    start_s = (state_r == ST_IDLE) && (m0_req || m1_req);

    if (pick_m1_s) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end

    sel_mapped_s = ({1'b0, sel_addr_s[15:12]} < 5'(NUM_SUB));

    for (int k = 0; k < NUM_SUB; k++) begin
      sel_en_s[k] = sel_we_s && sel_mapped_s && (sel_addr_s[15:12] == 4'(k));
    end
  end

  // Select the addressed bank's read data and form the response word.
  always_comb begin
    rd_slice_s = '0;
    for (int k = 0; k < NUM_SUB; k++) begin
      rd_slice_s = rd_slice_s | (sub_rd_data[k*DW +: DW] & {DW{bank_r == 4'(k)}});
    end

    if (we_r) begin
      rsp_data_s = '0;
    end else if (!mapped_r) begin
      rsp_data_s = ERR_DATA;
    end else begin
      rsp_data_s = rd_slice_s;
    end
  end

  // Transaction FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_gnt_r   <= 1'b1;
      win_r        <= 1'b0;
      we_r         <= 1'b0;
      bank_r       <= 4'h0;
      mapped_r     <= 1'b0;
      m0_gnt       <= 1'b0;
      m1_gnt       <= 1'b0;
      m0_rvalid    <= 1'b0;
      m1_rvalid    <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
      sub_reg_addr <= 12'h000;
      reg_wr_data  <= '0;
      sub_wr_en    <= '0;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r      <= ST_XFER;
            last_gnt_r   <= pick_m1_s;
            win_r        <= pick_m1_s;
            we_r         <= sel_we_s;
            bank_r       <= sel_addr_s[15:12];
            mapped_r     <= sel_mapped_s;
            sub_reg_addr <= sel_addr_s[11:0];
            reg_wr_data  <= sel_wdata_s;
            sub_wr_en    <= sel_en_s;
            m0_gnt       <= ~pick_m1_s;
            m1_gnt       <= pick_m1_s;
            busy         <= 1'b1;
          end
        end
        ST_XFER: begin
          // Bank read data is sampled here, one cycle after the address was driven.
          state_r   <= ST_RESP;
          m0_gnt    <= 1'b0;
          m1_gnt    <= 1'b0;
          sub_wr_en <= '0;
          m0_rvalid <= ~win_r;
          m1_rvalid <= win_r;
          m0_rdata  <= win_r ? '0 : rsp_data_s;
          m1_rdata  <= win_r ? rsp_data_s : '0;
          m0_err    <= ~win_r & ~mapped_r;
          m1_err    <= win_r & ~mapped_r;
        end
        ST_RESP: begin
          state_r   <= ST_IDLE;
          m0_rvalid <= 1'b0;
          m1_rvalid <= 1'b0;
          m0_rdata  <= '0;
          m1_rdata  <= '0;
          m0_err    <= 1'b0;
          m1_err    <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          m0_gnt    <= 1'b0;
          m1_gnt    <= 1'b0;
          sub_wr_en <= '0;
          m0_rvalid <= 1'b0;
          m1_rvalid <= 1'b0;
          m0_rdata  <= '0;
          m1_rdata  <= '0;
          m0_err    <= 1'b0;
          m1_err    <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arb.sv
// Directed bench for reg_bus_arb with a 4-bank read-data model.
module tb_reg_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [11:0] sub_reg_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  sub_wr_en;
  logic [127:0] sub_rd_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  reg_bus_arb #(.NUM_SUB(4), .DW(32), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .sub_reg_addr(sub_reg_addr), .reg_wr_data(reg_wr_data), .sub_wr_en(sub_wr_en),
    .sub_rd_data(sub_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bank k returns {k in top nibble} | (register address / 4).
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sub_rd_data[k*32 +: 32] = (32'(k) << 28) | (32'(sub_reg_addr) >> 2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction from requester m; expected values supplied by caller.
  task automatic do_txn(input logic m, input logic we, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic [3:0] exp_en);
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
    tick();
    chk("xfer_gnt", {m1_gnt, m0_gnt}, m ? 32'd2 : 32'd1);
    chk("xfer_wr_en", 32'(sub_wr_en), 32'(exp_en));
    chk("xfer_addr", 32'(sub_reg_addr), 32'(addr[11:0]));
    chk("xfer_wdata", reg_wr_data, wdata);
    chk("xfer_busy", 32'(busy), 32'd1);
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    chk("resp_rvalid", {m1_rvalid, m0_rvalid}, m ? 32'd2 : 32'd1);
    chk("resp_rdata", m ? m1_rdata : m0_rdata, exp_rdata);
    chk("resp_other_rdata", m ? m0_rdata : m1_rdata, 32'h0);
    chk("resp_err", {m1_err, m0_err}, exp_err ? (m ? 32'd2 : 32'd1) : 32'd0);
    chk("resp_wr_en", 32'(sub_wr_en), 32'd0);
    chk("resp_gnt", {m1_gnt, m0_gnt}, 32'd0);
    tick();
    chk("idle_rvalid", {m1_rvalid, m0_rvalid}, 32'd0);
    chk("idle_rdata", m0_rdata | m1_rdata, 32'h0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_hold_addr", 32'(sub_reg_addr), 32'(addr[11:0]));
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0000; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'h0000; m1_wdata = 32'h0;

    // T1: reset held two cycles with m0 requesting
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_gnt", {m1_gnt, m0_gnt}, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_en", 32'(sub_wr_en), 32'd0);
      chk("rst_addr", 32'(sub_reg_addr), 32'd0);
      chk("rst_wdata", reg_wr_data, 32'h0);
      chk("rst_rvalid", {m1_rvalid, m0_rvalid, m1_err, m0_err}, 32'd0);
      chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    end
    rst = 1'b0;
    // first grant appears in the cycle after the first non-reset edge
    do_txn(1'b0, 1'b0, 16'h0000, 32'h0, 32'h0000_0000, 1'b0, 4'b0000);

    // T2: write bank1
    do_txn(1'b0, 1'b1, 16'h1004, 32'h55, 32'h0, 1'b0, 4'b0010);
    // T3: read bank0 addr 8 -> 2
    do_txn(1'b1, 1'b0, 16'h0008, 32'h0, 32'h0000_0002, 1'b0, 4'b0000);
    // read bank3 addr 0x010 -> 0x3000_0004
    do_txn(1'b1, 1'b0, 16'h3010, 32'h0, 32'h3000_0004, 1'b0, 4'b0000);
    // write bank3 (top mapped bank)
    do_txn(1'b1, 1'b1, 16'h3FFC, 32'hA5A5_0001, 32'h0, 1'b0, 4'b1000);

    // T4: contention; last grant was m1 so m0 goes first
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h2000; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0004; m1_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_gnt", {m1_gnt, m0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_addr", 32'(sub_reg_addr), (i % 2 == 0) ? 32'h000 : 32'h004);
      tick();
      chk("rr_resp_gnt", {m1_gnt, m0_gnt}, 32'd0);
      chk("rr_rvalid", {m1_rvalid, m0_rvalid}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_rdata", (i % 2 == 0) ? m0_rdata : m1_rdata,
          (i % 2 == 0) ? 32'h2000_0000 : 32'h0000_0001);
      if (i == 3) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      tick();
      chk("rr_idle_gnt", {m1_gnt, m0_gnt}, 32'd0);
    end
    tick();
    chk("rr_drained", {m1_gnt, m0_gnt, 30'(busy)}, 32'd0);

    // T5: unmapped read and write
    do_txn(1'b0, 1'b0, 16'h5000, 32'h0, 32'hDEAD_BEEF, 1'b1, 4'b0000);
    do_txn(1'b0, 1'b1, 16'hF123, 32'h77, 32'h0, 1'b1, 4'b0000);

    // T6: reset during XFER of a granted write
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h2008; m0_wdata = 32'h1234_5678;
    tick();
    chk("t6_gnt", 32'(m0_gnt), 32'd1);
    chk("t6_wr_en", 32'(sub_wr_en), 32'b0100);
    m0_req = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_wr_en_off", 32'(sub_wr_en), 32'd0);
    chk("t6_rvalid", {m1_rvalid, m0_rvalid}, 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_addr", 32'(sub_reg_addr), 32'd0);
    rst = 1'b0;
    tick();
    chk("t6_no_rvalid", {m1_rvalid, m0_rvalid, m1_gnt, m0_gnt}, 32'd0);
    // last_gnt back to m1, so m0 wins a tie
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0000;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0000;
    tick();
    chk("t6_tie_m0", {m1_gnt, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    tick();
    chk("t6_end_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
